// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the TDC core: drives launch/capture strobes, accumulates
// 2^log_n hamming-weight samples and returns sum/avg/min/max over a valid/ready port.
module tdc_meas_ctrl #(
  parameter int N          = 64,
  parameter int MAX_LOG    = 8,
  parameter int SETTLE_CYC = 3,
  parameter int DLY_W      = 8,
  localparam int HW_W      = $clog2(N) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DLY_W-1:0]        cfg_cap_dly,
  input  logic [3:0]              cfg_log_n,
  input  logic                    cfg_tog,
  input  logic [HW_W-1:0]         hw_in,
  output logic                    clk_launch,
  output logic                    clk_capture,
  output logic                    pg_tog,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [HW_W+MAX_LOG-1:0] res_sum,
  output logic [HW_W-1:0]         res_avg,
  output logic [HW_W-1:0]         res_min,
  output logic [HW_W-1:0]         res_max
);

  localparam int SUM_W = HW_W + MAX_LOG;
  localparam int CNT_W = MAX_LOG + 1;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [3:0]      MAX_LOG_L = 4'(MAX_LOG);
  localparam logic [SC_W-1:0] SC_LOAD   = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_CAP, CAPTURE, SETTLE, SAMPLE, RESULT
  } state_t;

  state_t state, state_nx;

  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] wcnt;
  logic [SC_W-1:0]  scnt;
  logic [3:0]       log_n;
  logic             tog_en;
  logic [SUM_W-1:0] acc_sum, sum_nx;
  logic [HW_W-1:0]  acc_min, acc_max, min_nx, max_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             last;

  always_comb begin
    sum_nx   = acc_sum + SUM_W'(hw_in);
    min_nx   = (hw_in < acc_min) ? hw_in : acc_min;
    max_nx   = (hw_in > acc_max) ? hw_in : acc_max;
    count_nx = count + CNT_W'(1);
    last     = (count_nx == (CNT_W'(1) << log_n));
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = LAUNCH;
      LAUNCH:   state_nx = (dly != '0) ? WAIT_CAP : CAPTURE;
      WAIT_CAP: if (wcnt == '0) state_nx = CAPTURE;
      CAPTURE:  state_nx = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;
      SETTLE:   if (scnt == '0) state_nx = SAMPLE;
      SAMPLE:   state_nx = last ? RESULT : LAUNCH;
      RESULT:   if (res_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Outputs are registered from the next state so each strobe is high exactly
  // during the cycle its state is occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_launch  <= 1'b0;
      clk_capture <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      clk_launch  <= (state_nx == LAUNCH);
      clk_capture <= (state_nx == CAPTURE);
      busy        <= (state_nx != IDLE);
      res_valid   <= (state_nx == RESULT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly     <= '0;
      log_n   <= '0;
      tog_en  <= 1'b0;
      wcnt    <= '0;
      scnt    <= '0;
      acc_sum <= '0;
      acc_min <= '1;
      acc_max <= '0;
      count   <= '0;
      pg_tog  <= 1'b0;
      res_sum <= '0;
      res_avg <= '0;
      res_min <= '0;
      res_max <= '0;
    end else begin
      if (state == IDLE && state_nx == LAUNCH) begin
        dly     <= cfg_cap_dly;
        log_n   <= (cfg_log_n > MAX_LOG_L) ? MAX_LOG_L : cfg_log_n;
        tog_en  <= cfg_tog;
        acc_sum <= '0;
        acc_min <= '1;
        acc_max <= '0;
        count   <= '0;
      end
      if (state == LAUNCH && state_nx == WAIT_CAP) wcnt <= dly - DLY_W'(1);
      else if (state == WAIT_CAP && wcnt != '0)    wcnt <= wcnt - DLY_W'(1);
      if (state == CAPTURE && state_nx == SETTLE)  scnt <= SC_LOAD;
      else if (state == SETTLE && scnt != '0)      scnt <= scnt - SC_W'(1);
      if (state == SAMPLE && !abort) begin
        acc_sum <= sum_nx;
        acc_min <= min_nx;
        acc_max <= max_nx;
        count   <= count_nx;
        if (tog_en) pg_tog <= ~pg_tog;
        if (last) begin
          res_sum <= sum_nx;
          res_avg <= HW_W'(sum_nx >> log_n);
          res_min <= min_nx;
          res_max <= max_nx;
        end
      end
    end
  end

endmodule
